// File: rtl/char_glyph_source.sv
// Mine-index / revealed-flag table with a one-cycle glyph-row read path for the board draw stage.
// Optional macro CHAR_GLYPH_SHOW_ALL_EN: ignore the revealed flag when drawing (debug view).
module char_glyph_source #(
  parameter int unsigned MAX_FIELDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  button_num,
  input  logic [4:0]  char_x,
  input  logic [4:0]  char_y,
  input  logic [5:0]  char_line,
  output logic [49:0] char_pixels,
  input  logic        wr_en,
  input  logic [4:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [3:0]  wr_index,
  input  logic        reveal_en,
  input  logic        clear_req,
  output logic        busy
);

  localparam int unsigned DEPTH     = MAX_FIELDS * MAX_FIELDS;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned GW        = 10;
  localparam int unsigned SCALE     = 5;
  localparam int unsigned PW        = GW * SCALE;
  localparam int unsigned LAST_LINE = PW - 1;
  localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);

`ifdef CHAR_GLYPH_SHOW_ALL_EN
  localparam bit SHOW_ALL = 1'b1;
`else
  localparam bit SHOW_ALL = 1'b0;
`endif

  // Base 10x10 digit bitmaps, row 0 in the top bits, bit 9 of each row = leftmost column.
  localparam logic [10*GW-1:0] GLYPH_1 = {
    10'b0000000000, 10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
    10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_2 = {
    10'b0000000000, 10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000001100,
    10'b0000110000, 10'b0011000000, 10'b0110000000, 10'b0111111110, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_3 = {
    10'b0000000000, 10'b0111111100, 10'b0000000110, 10'b0000000110, 10'b0011111100,
    10'b0000000110, 10'b0000000110, 10'b0000000110, 10'b0111111100, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_4 = {
    10'b0000000000, 10'b0000011100, 10'b0000111100, 10'b0001101100, 10'b0011001100,
    10'b0111111110, 10'b0000001100, 10'b0000001100, 10'b0000001100, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_5 = {
    10'b0000000000, 10'b0111111110, 10'b0110000000, 10'b0110000000, 10'b0111111100,
    10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_6 = {
    10'b0000000000, 10'b0001111100, 10'b0011000000, 10'b0110000000, 10'b0111111100,
    10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_7 = {
    10'b0000000000, 10'b0111111110, 10'b0000000110, 10'b0000001100, 10'b0000011000,
    10'b0000110000, 10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0000000000
  };
  localparam logic [10*GW-1:0] GLYPH_8 = {
    10'b0000000000, 10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0011111100,
    10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000
  };

  // Returns base row r of digit idx; blank for any index outside 1..8.
  function automatic logic [GW-1:0] glyph_row(input logic [3:0] idx, input logic [3:0] r);
    logic [10*GW-1:0] g;
    logic [GW-1:0]    row;
    case (idx)
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      default: g = '0;
    endcase
    row = '0;
    for (int i = 0; i < 10; i++) begin
      if (r == 4'(i)) row = g[(9 - i) * GW +: GW];
    end
    return row;
  endfunction

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e          state_q;
  logic [AW-1:0]   sweep_q;
  logic            busy_q;
  logic [PW-1:0]   pix_q;
  logic [PW-1:0]   pix_d;

  logic [3:0]      idx_mem [DEPTH];
  logic            rev_mem [DEPTH];

  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [3:0]      rd_idx;
  logic            rd_rev;
  logic            rd_ok;
  logic            wr_ok;
  logic [GW-1:0]   base_row;

  assign rd_addr = AW'(32'(char_y) * MAX_FIELDS + 32'(char_x));
  assign wr_addr = AW'(32'(wr_y) * MAX_FIELDS + 32'(wr_x));

  // Asynchronous table read so lookup and expansion fit before the output register.
  assign rd_idx = idx_mem[rd_addr];
  assign rd_rev = rev_mem[rd_addr];

  assign rd_ok = (char_x < button_num) && (char_y < button_num) &&
                 (32'(char_x) < MAX_FIELDS) && (32'(char_y) < MAX_FIELDS) &&
                 (char_line <= 6'(LAST_LINE)) && !busy_q;

  assign wr_ok = !rst && !busy_q && (32'(wr_x) < MAX_FIELDS) && (32'(wr_y) < MAX_FIELDS);

  // Glyph expansion: each base bit becomes SCALE adjacent pixels.
  always_comb begin
    pix_d    = '0;
    base_row = glyph_row(rd_idx, 4'(char_line / 6'd5));
    if (rd_ok && (rd_rev || SHOW_ALL) && (rd_idx != 4'd0) && (rd_idx <= 4'd8)) begin
      for (int b = 0; b < GW; b++) begin
        pix_d[b * SCALE +: SCALE] = {SCALE{base_row[b]}};
      end
    end
  end

  // Single write port: the clear sweep owns it while busy, otherwise game-logic writes.
  always_ff @(posedge clk) begin
    if (busy_q && !rst) begin
      idx_mem[sweep_q] <= '0;
      rev_mem[sweep_q] <= 1'b0;
    end else begin
      if (wr_ok && wr_en)     idx_mem[wr_addr] <= wr_index;
      if (wr_ok && reveal_en) rev_mem[wr_addr] <= 1'b1;
    end
  end

  // Clear sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      pix_q <= pix_d;
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (sweep_q == LAST_ENTRY) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign char_pixels = pix_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_char_glyph_source.sv
// Bench for char_glyph_source: cycle-level reference model plus directed literal checks.
module tb_char_glyph_source;

`ifdef CHAR_GLYPH_SHOW_ALL_EN
  localparam bit SHOW_ALL = 1'b1;
`else
  localparam bit SHOW_ALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  button_num;
  logic [4:0]  char_x, char_y;
  logic [5:0]  char_line;
  logic [49:0] char_pixels;
  logic        wr_en;
  logic [4:0]  wr_x, wr_y;
  logic [3:0]  wr_index;
  logic        reveal_en;
  logic        clear_req;
  logic        busy;

  int tests = 0;
  int fails = 0;

  char_glyph_source dut (
    .clk        (clk),
    .rst        (rst),
    .button_num (button_num),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_line  (char_line),
    .char_pixels(char_pixels),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_index   (wr_index),
    .reveal_en  (reveal_en),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Font drawn as text, 10 rows of 10 characters per digit, '#' = lit.
  string font [1:8];
  initial begin
    automatic string b = "..........";
    font[1] = {b, "....##....", "....##....", "....##....", "....##....",
               "....##....", "....##....", "....##....", "....##....", b};
    font[2] = {b, "..######..", ".##....##.", ".......##.", "......##..",
               "....##....", "..##......", ".##.......", ".########.", b};
    font[3] = {b, ".#######..", ".......##.", ".......##.", "..######..",
               ".......##.", ".......##.", ".......##.", ".#######..", b};
    font[4] = {b, ".....###..", "....####..", "...##.##..", "..##..##..",
               ".########.", "......##..", "......##..", "......##..", b};
    font[5] = {b, ".########.", ".##.......", ".##.......", ".#######..",
               ".......##.", ".......##.", ".##....##.", "..######..", b};
    font[6] = {b, "...#####..", "..##......", ".##.......", ".#######..",
               ".##....##.", ".##....##.", ".##....##.", "..######..", b};
    font[7] = {b, ".########.", ".......##.", "......##..", ".....##...",
               "....##....", "...##.....", "...##.....", "...##.....", b};
    font[8] = {b, "..######..", ".##....##.", ".##....##.", "..######..",
               ".##....##.", ".##....##.", ".##....##.", "..######..", b};
  end

  // Reference state: the board as a 2-D grid plus a clear-in-progress flag.
  bit [3:0] m_idx [0:31][0:31];
  bit       m_rev [0:31][0:31];
  bit       m_busy = 1'b0;
  int       swept  = 0;
  logic [49:0] exp_pix = '0;
  bit       model_valid = 1'b0;

  function automatic logic [49:0] model_row(int x, int y, int line, int nb, bit bsy);
    logic [49:0] res;
    int d, r;
    res = '0;
    if (bsy || x >= nb || y >= nb || line > 49) return res;
    d = int'(m_idx[y][x]);
    if (!(m_rev[y][x] || SHOW_ALL) || d < 1 || d > 8) return res;
    r = line / 5;
    for (int c = 0; c < 50; c++) res[49 - c] = (font[d][r * 10 + c / 5] == "#");
    return res;
  endfunction

  task automatic check(string name, logic [49:0] got, logic [49:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Model step: the read sees the table as it was before this edge's writes.
  always @(posedge clk) begin
    if (rst) begin
      exp_pix = '0;
      m_busy  = 1'b0;
    end else begin
      exp_pix = model_row(int'(char_x), int'(char_y), int'(char_line), int'(button_num), m_busy);
      if (m_busy) begin
        m_idx[swept / 32][swept % 32] = 4'd0;
        m_rev[swept / 32][swept % 32] = 1'b0;
        swept++;
        if (swept == 1024) m_busy = 1'b0;
      end else begin
        if (clear_req) begin
          m_busy = 1'b1;
          swept  = 0;
        end
        if (wr_en)     m_idx[wr_y][wr_x] = wr_index;
        if (reveal_en) m_rev[wr_y][wr_x] = 1'b1;
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_pixels", char_pixels, exp_pix);
      check("model_busy", 50'(busy), 50'(m_busy));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic request(int x, int y, int line);
    char_x    = 5'(x);
    char_y    = 5'(y);
    char_line = 6'(line);
  endtask

  initial begin
    int n;
    rst = 1'b1; button_num = '0; char_x = '0; char_y = '0; char_line = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_index = '0; reveal_en = 1'b0; clear_req = 1'b0;
    tick(3);
    check("reset_pixels", char_pixels, 50'd0);
    check("reset_busy", 50'(busy), 50'd0);
    rst = 1'b0;
    tick(1);

    // Initial clear, then ask for a field while sweeping.
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    button_num = 5'd8;
    request(2, 3, 10);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(1); end
    check("clear1_busy_cycles", 50'(n), 50'd1024);
    tick(1);
    check("after_clear_blank", char_pixels, 50'd0);

    // Digit 1 at (2,3): row 2 lights base columns 4..5 -> pixels 20..29 -> bits 29:20.
    wr_en = 1'b1; wr_x = 5'd2; wr_y = 5'd3; wr_index = 4'd1;
    tick(1);
    wr_en = 1'b0; reveal_en = 1'b1;
    tick(1);
    reveal_en = 1'b0;
    tick(1);
    check("digit1_line10", char_pixels, 50'h0_0000_3FF0_0000);
    request(2, 3, 2);
    tick(1);
    check("digit1_blank_row0", char_pixels, 50'd0);
    request(2, 3, 50);
    tick(1);
    check("line50_blank", char_pixels, 50'd0);
    request(8, 3, 10);
    tick(1);
    check("x_at_button_num_blank", char_pixels, 50'd0);
    for (int l = 0; l < 52; l++) begin request(2, 3, l); tick(1); end

    // Same-cycle write/read: old digit 1 first, digit 8 row 2 on the next request.
    request(2, 3, 10);
    wr_en = 1'b1; wr_x = 5'd2; wr_y = 5'd3; wr_index = 4'd8;
    tick(1);
    wr_en = 1'b0;
    check("raw_old_value", char_pixels, 50'h0_0000_3FF0_0000);
    tick(1);
    check("raw_new_value", char_pixels, 50'h0_1FF8_0000_7FE0);

    // Index write and reveal together; digit 2 row 1 lights columns 2..7 -> bits 39:10.
    wr_en = 1'b1; reveal_en = 1'b1; wr_x = 5'd1; wr_y = 5'd1; wr_index = 4'd2;
    tick(1);
    wr_en = 1'b0; reveal_en = 1'b0;
    request(1, 1, 5);
    tick(1);
    check("both_strobes_digit2", char_pixels, 50'h0_00FF_FFFF_FC00);

    // Index 9 is outside the font.
    wr_en = 1'b1; reveal_en = 1'b1; wr_x = 5'd4; wr_y = 5'd4; wr_index = 4'd9;
    tick(1);
    wr_en = 1'b0; reveal_en = 1'b0;
    request(4, 4, 20);
    tick(1);
    check("index9_blank", char_pixels, 50'd0);

    // Every digit on row 0 of the board, read across a few lines.
    for (int d = 1; d <= 8; d++) begin
      wr_en = 1'b1; reveal_en = 1'b1; wr_x = 5'(d - 1); wr_y = 5'd0; wr_index = 4'(d);
      tick(1);
    end
    wr_en = 1'b0; reveal_en = 1'b0;
    for (int d = 1; d <= 8; d++) begin
      for (int l = 3; l < 50; l += 7) begin request(d - 1, 0, l); tick(1); end
    end

    // Unrevealed digit 3, row 3 lights base columns 7..8 -> bits 14:5 when shown.
    wr_en = 1'b1; wr_x = 5'd5; wr_y = 5'd5; wr_index = 4'd3;
    tick(1);
    wr_en = 1'b0;
    request(5, 5, 15);
    tick(1);
    check("unrevealed_digit3", char_pixels, SHOW_ALL ? 50'h0_0000_0000_7FE0 : 50'd0);

    // Write and second clear_req mid-sweep are both dropped; (2,0) was already swept.
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 100) begin
        wr_en = 1'b1; reveal_en = 1'b1; wr_x = 5'd2; wr_y = 5'd0; wr_index = 4'd4; clear_req = 1'b1;
      end else begin
        wr_en = 1'b0; reveal_en = 1'b0; clear_req = 1'b0;
      end
      tick(1);
    end
    check("clear2_busy_cycles", 50'(n), 50'd1024);
    request(2, 0, 20);
    tick(1);
    check("dropped_write_blank", char_pixels, 50'd0);

    // clear_req held: one idle cycle after the first sweep, then a second sweep.
    clear_req = 1'b1;
    tick(1030);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(1); end
    check("held_clear_tail", 50'(n), 50'd1020);

    // Reset halfway through a sweep, then a full sweep again.
    request(2, 3, 10);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(499);
    rst = 1'b1;
    tick(1);
    check("rst_mid_clear_busy", 50'(busy), 50'd0);
    check("rst_mid_clear_pixels", char_pixels, 50'd0);
    rst = 1'b0;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(1); end
    check("clear3_busy_cycles", 50'(n), 50'd1024);
    tick(2);
    check("final_blank", char_pixels, 50'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
